// File: rtl/stopwatch_pkg.sv
// Shared types and defaults for the stopwatch control slice.
// No logic; no latency; no flow control.
// Enum encodings are visible on the debug/LED state port.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUNNING = 2'd1,
        STOPPED = 2'd2,
        LAP     = 2'd3
    } state_t;

    localparam int LOCKOUT_CYCLES_DEF = 4;

endpackage

// File: rtl/press_lockout.sv
// Post-press lockout: accepts a button edge only when the down-counter is idle; ss beats lr.
// Latency: accept outputs are combinational from the edges; lockout starts the next cycle.
// Backpressure: none; presses arriving during lockout are dropped.
module press_lockout
    import stopwatch_pkg::*;
#(
    parameter int LOCKOUT_CYCLES = LOCKOUT_CYCLES_DEF
) (
    input  logic clk,
    input  logic n_rst,
    input  logic ss_edge,
    input  logic lr_edge,
    output logic accept_ss,
    output logic accept_lr
);

    // A zero lockout still needs a 1-bit counter; it is simply always reloaded with 0.
    localparam int CNT_W = (LOCKOUT_CYCLES > 0) ? $clog2(LOCKOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(LOCKOUT_CYCLES);

    logic [CNT_W-1:0] cnt;
    logic             open;
    logic             any_press;

    assign open      = (cnt == '0);
    assign any_press = ss_edge | lr_edge;
    assign accept_ss = open & ss_edge;
    assign accept_lr = open & lr_edge & ~ss_edge;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt <= '0;
        end else if (open && any_press) begin
            cnt <= LOAD_VAL;
        end else if (!open) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM: sequences counter enable/clear and lap capture; lap mode under STOPWATCH_LAP_EN.
// Latency: press in cycle N changes state/pulses in N+1; count_inc is combinational with tick.
// Backpressure: none; tick is never stalled, presses in lockout are discarded.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int LOCKOUT_CYCLES = LOCKOUT_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       ss_edge,
    input  logic       lr_edge,
    input  logic       tick,
    output logic       count_en,
    output logic       count_inc,
    output logic       count_clr,
    output logic       lap_capture,
    output logic       freeze,
    output logic [1:0] state
);

    state_t cur;
    logic   accept_ss;
    logic   accept_lr;
`ifdef STOPWATCH_LAP_EN
    logic   lap_q;
`endif

    press_lockout #(
        .LOCKOUT_CYCLES(LOCKOUT_CYCLES)
    ) u_lockout (
        .clk      (clk),
        .n_rst    (n_rst),
        .ss_edge  (ss_edge),
        .lr_edge  (lr_edge),
        .accept_ss(accept_ss),
        .accept_lr(accept_lr)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cur       <= IDLE;
            count_clr <= 1'b0;
`ifdef STOPWATCH_LAP_EN
            lap_q     <= 1'b0;
`endif
        end else begin
            count_clr <= 1'b0;
`ifdef STOPWATCH_LAP_EN
            lap_q     <= 1'b0;
`endif
            case (cur)
                IDLE: begin
                    if (accept_ss) cur <= RUNNING;
                end
                RUNNING: begin
                    if (accept_ss) begin
                        cur <= STOPPED;
`ifdef STOPWATCH_LAP_EN
                    end else if (accept_lr) begin
                        cur   <= LAP;
                        lap_q <= 1'b1;
`endif
                    end
                end
                STOPPED: begin
                    if (accept_ss) begin
                        cur <= RUNNING;
                    end else if (accept_lr) begin
                        cur       <= IDLE;
                        count_clr <= 1'b1;
                    end
                end
`ifdef STOPWATCH_LAP_EN
                LAP: begin
                    if (accept_ss) begin
                        cur <= STOPPED;
                    end else if (accept_lr) begin
                        lap_q <= 1'b1;
                    end
                end
`endif
                default: cur <= IDLE;
            endcase
        end
    end

    assign state     = cur;
    assign count_en  = (cur == RUNNING) || (cur == LAP);
    assign count_inc = count_en & tick;
`ifdef STOPWATCH_LAP_EN
    assign lap_capture = lap_q;
    assign freeze      = (cur == LAP);
`else
    assign lap_capture = 1'b0;
    assign freeze      = 1'b0;
`endif

endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Control FSM for the stopwatch. It consumes the single-cycle edge pulses from the two button synchronizer/edge-detector instances (start/stop and lap/reset) and sequences the time-counter datapath: enable, clear and lap capture/freeze. A post-press lockout window rejects contact bounce that survives synchronization. It sits between the button edge detectors and the BCD time counter/display registers.

## Interface
- LOCKOUT_CYCLES, default 4: cycles after an accepted press during which all further presses are ignored; 0 disables the lockout.
- clk  in  1  system clock
- n_rst  in  1  asynchronous active-low reset
- ss_edge  in  1  start/stop press; one-cycle pulse, synchronous to clk
- lr_edge  in  1  lap/reset press; one-cycle pulse, synchronous to clk
- tick  in  1  timebase pulse (e.g. 100 Hz strobe), one cycle wide
- count_en  out  1  counter is running (state RUNNING or LAP)
- count_inc  out  1  count_en & tick; combinational, same cycle as tick
- count_clr  out  1  registered one-cycle clear pulse to the time counter
- lap_capture  out  1  registered one-cycle pulse; display register loads the current time
- freeze  out  1  display shows the captured lap value (state LAP)
- state  out  2  current FSM state, for debug/LEDs

## Operation
- States: IDLE=0, RUNNING=1, STOPPED=2, LAP=3.
- Accepted press means the edge is asserted while the lockout counter is 0. Every accepted press, even one that causes no transition, loads the lockout counter with LOCKOUT_CYCLES.
- IDLE: ss → RUNNING; lr has no effect.
- RUNNING: ss → STOPPED; lr → LAP, with lap_capture pulse.
- LAP: ss → STOPPED and the display unfreezes; lr → LAP with a new lap_capture pulse (lap refresh); counting continues throughout.
- STOPPED: ss → RUNNING; lr → IDLE, with count_clr pulse.
- Simultaneous ss and lr in the same cycle: ss wins and lr is discarded. The lockout is loaded once.
- Lockout counter width is $clog2(LOCKOUT_CYCLES+1). It decrements to 0 and saturates there; it never wraps.
- tick is never lost or delayed. count_inc follows the current state only.

## Timing
- Reset, asynchronous: state=IDLE, lockout=0, count_clr=0, lap_capture=0. Therefore count_en=0, count_inc=0, freeze=0.
- Outputs are Moore-style from registered state. The exception is count_inc, which is gated by tick combinationally.
- Latency: press in cycle N → state and count_en change in cycle N+1. count_clr or lap_capture is high for cycle N+1 only.
- Lockout: a press accepted in cycle N blocks presses in cycles N+1 … N+LOCKOUT_CYCLES. A press at N+LOCKOUT_CYCLES+1 is accepted.
- A tick in the same cycle as the accepted stop press still produces count_inc, because the state is still RUNNING.
- Reset asserted mid-operation returns to IDLE immediately and aborts any pending pulse.

## Configuration
- STOPWATCH_LAP_EN defined: LAP state and lap_capture behave as described above.
- Not defined: LAP is unreachable. lr in RUNNING is ignored but still loads the lockout. lap_capture is tied to 0 and freeze is tied to 0.

## Structure
- stopwatch_pkg holds:
  - the state_t enum (2-bit, encodings above);
  - the default LOCKOUT_CYCLES localparam, shared with the top level.
- One sub-module, press_lockout, contains the loadable down-counter. It takes any_press in and gives accept_ss/accept_lr out, applying the priority rule.
- The FSM and output registers stay in stopwatch_ctrl.

## Test plan
- Reset check: hold n_rst low, then release. Expect state=0, and count_en, count_clr, lap_capture and freeze all 0. Apply 10 ticks and expect count_inc=0 throughout.
- Start/stop:
  - ss pulse at cycle 5 → state=1 and count_en=1 at cycle 6.
  - 3 ticks → 3 count_inc pulses.
  - ss at cycle 20 → state=2 at cycle 21.
  - Further ticks produce no count_inc.
- Reset from stopped: in STOPPED, an lr pulse at cycle N → state=0 and a count_clr pulse only at N+1. An lr in IDLE → no count_clr.
- Lap (STOPWATCH_LAP_EN): in RUNNING, lr → state=3, lap_capture=1 for one cycle, freeze=1 and count_en=1. A second lr (after the lockout) → another lap_capture. ss → state=2 and freeze=0.
- Lockout (LOCKOUT_CYCLES=4): ss accepted at cycle 10; ss at 12 and lr at 14 ignored; ss at 15 accepted (RUNNING→STOPPED→RUNNING).
- Simultaneous presses: ss and lr in the same cycle from RUNNING → STOPPED, with no lap_capture. A tick coincident with that press → one count_inc.
